// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and width helper for the single-clock FIFO
package fifo_pkg;

  localparam int DEF_ADD  = 3;
  localparam int DEF_DATA = 8;

  localparam int FWFT_OFF = 0;
  localparam int FWFT_ON  = 1;

  // Pointers and count carry one extra wrap bit so full and empty are distinguishable.
  function automatic int cnt_w(input int add);
    return add + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// rtl/sync_fifo_if.sv - producer/consumer handshake and status bundle for sync_fifo
interface sync_fifo_if
  import fifo_pkg::*;
#(
  parameter int ADD  = DEF_ADD,
  parameter int DATA = DEF_DATA
);

  logic                    w_en;
  logic [DATA-1:0]         wdata;
  logic                    r_en;
  logic                    flush;
  logic                    clr_err;
  logic [DATA-1:0]         rdata;
  logic                    rvalid;
  logic                    full;
  logic                    empty;
  logic                    almost_full;
  logic                    almost_empty;
  logic [cnt_w(ADD)-1:0]   count;
  logic                    ovf;
  logic                    unf;

  modport master (
    output w_en, wdata, r_en, flush, clr_err,
    input  rdata, rvalid, full, empty, almost_full, almost_empty, count, ovf, unf
  );

  modport slave (
    input  w_en, wdata, r_en, flush, clr_err,
    output rdata, rvalid, full, empty, almost_full, almost_empty, count, ovf, unf
  );

endinterface

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - 2**ADD x DATA register array, sync write port, combinational read port
module fifo_mem #(
  parameter int ADD  = 3,
  parameter int DATA = 8
) (
  input  logic            clk,
  input  logic            we,
  input  logic [ADD-1:0]  waddr,
  input  logic [DATA-1:0] wdata,
  input  logic [ADD-1:0]  raddr,
  output logic [DATA-1:0] rdata
);

  logic [DATA-1:0] mem [2**ADD];

  // Contents are deliberately not reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with thresholds, sticky errors, flush and FWFT option
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int ADD   = DEF_ADD,
  parameter int DATA  = DEF_DATA,
  parameter int AF_TH = 2**ADD - 2,
  parameter int AE_TH = 1,
  parameter int FWFT  = FWFT_OFF
) (
  input  logic      clk,
  input  logic      rst,
  sync_fifo_if.slave bus
);

  localparam int CW = cnt_w(ADD);
  localparam logic [CW-1:0] AF_C = CW'(AF_TH);
  localparam logic [CW-1:0] AE_C = CW'(AE_TH);

  if (AF_TH < 0 || AF_TH > 2**ADD || AE_TH < 0 || AE_TH > 2**ADD) begin : g_bad_th
    $error("sync_fifo: AF_TH/AE_TH must lie within 0..2**ADD");
  end

  logic [CW-1:0]   wptr, rptr, cnt;
  logic            empty, full, wr_acc, rd_acc;
  logic [DATA-1:0] mem_rd;

  assign empty  = (wptr == rptr);
  assign full   = (wptr[ADD] != rptr[ADD]) && (wptr[ADD-1:0] == rptr[ADD-1:0]);
  assign cnt    = wptr - rptr;
  assign wr_acc = bus.w_en && !full  && !bus.flush;
  assign rd_acc = bus.r_en && !empty && !bus.flush;

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.count        = cnt;
  assign bus.almost_full  = (cnt >= AF_C);
  assign bus.almost_empty = (cnt <= AE_C);

  fifo_mem #(.ADD(ADD), .DATA(DATA)) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wptr[ADD-1:0]),
    .wdata (bus.wdata),
    .raddr (rptr[ADD-1:0]),
    .rdata (mem_rd)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else if (bus.flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_acc) wptr <= wptr + 1'b1;
      if (rd_acc) rptr <= rptr + 1'b1;
    end
  end

  // A fresh error outranks clr_err in the same cycle; flush neither sets nor clears.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.ovf <= 1'b0;
      bus.unf <= 1'b0;
    end else begin
      if (bus.w_en && full && !bus.flush)       bus.ovf <= 1'b1;
      else if (bus.clr_err)                     bus.ovf <= 1'b0;
      if (bus.r_en && empty && !bus.flush)      bus.unf <= 1'b1;
      else if (bus.clr_err)                     bus.unf <= 1'b0;
    end
  end

  if (FWFT == FWFT_ON) begin : g_fwft
    assign bus.rdata  = mem_rd;
    assign bus.rvalid = !empty;
  end else begin : g_std
    logic [DATA-1:0] rdata_q;
    logic            rvalid_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else begin
        rvalid_q <= rd_acc;
        if (rd_acc) rdata_q <= mem_rd;
      end
    end

    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
  end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parametrised FIFO with integrated storage, occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, synchronous flush and selectable standard or first-word-fall-through (FWFT) read mode. It is the single-clock-domain counterpart of the team's gray-pointer asynchronous FIFO logic and serves as the buffering primitive wherever producer and consumer share a clock.

## Interface
- ADD, 3: address width; depth = 2**ADD
- DATA, 8: data width
- AF_TH, 2**ADD-2: almost_full asserted when count >= AF_TH
- AE_TH, 1: almost_empty asserted when count <= AE_TH
- FWFT, 0: 0 = standard registered read, 1 = first-word-fall-through
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous active-low reset
- w_en  in  1  write request
- wdata  in  DATA  write data
- r_en  in  1  read (pop) request
- flush  in  1  synchronous clear of contents
- clr_err  in  1  synchronous clear of ovf/unf
- rdata  out  DATA  read data
- rvalid  out  1  rdata holds a valid popped word (FWFT=0) / head word present (FWFT=1)
- full, empty, almost_full, almost_empty  out  1  status flags
- count  out  ADD+1  occupancy, 0..2**ADD
- ovf, unf  out  1  sticky overflow / underflow

## Operation
- Pointers wptr/rptr: ADD+1-bit binary; low ADD bits address memory, MSB is wrap bit. Wrap from 2**(ADD+1)-1 to 0 is natural modulo.
- empty = (wptr == rptr); full = (wptr[ADD] != rptr[ADD]) && (wptr[ADD-1:0] == rptr[ADD-1:0]); count = wptr - rptr modulo 2**(ADD+1). All derived from registered pointers, so flags are glitch-free functions of state.
- Write accepted iff w_en && !full: mem[wptr] <= wdata, wptr+1.
- Read accepted iff r_en && !empty: rptr+1.
- Simultaneous accepted read and write: both proceed, count unchanged. When full, a write is NOT accepted even if a read is accepted the same cycle; when empty, a read is NOT accepted even if a write occurs the same cycle.
- Rejected write (w_en && full) sets ovf; rejected read (r_en && empty) sets unf. Both sticky until clr_err or reset; if clr_err and a new error coincide, the error wins (flag stays 1).
- flush: pointers to 0, rvalid to 0 (FWFT=0); overrides w_en/r_en that cycle; does not alter ovf/unf, does not set them.
- FWFT=0: on accepted read, rdata <= mem[rptr], rvalid <= 1; rvalid <= 0 in any cycle without an accepted read; rdata holds last value otherwise.
- FWFT=1: rdata = mem[rptr[ADD-1:0]] combinationally; rvalid = !empty; r_en acknowledges the presented word.
- Memory contents are not reset.

## Timing
- Reset values: full 0, empty 1, almost_full 0, almost_empty 1, count 0, ovf 0, unf 0, rdata 0, rvalid 0; pointers 0. Reset mid-operation discards all contents immediately (asynchronous).
- Write at edge k: empty/count/almost_* reflect it after edge k; a word written at edge k is readable by r_en sampled at edge k+1.
- FWFT=0 read latency: r_en accepted at edge k -> rdata/rvalid valid after edge k, for one cycle.
- FWFT=1: head word visible after the edge that wrote it into an empty FIFO.
- Flags update after the same edge that moves the pointer; no additional pipeline stage.

## Structure
- Shared package fifo_pkg: default parameter constants (ADD, DATA), mode constants FWFT_OFF/FWFT_ON, and a count/pointer width function.
- Sub-module fifo_mem: 2**ADD x DATA register array, one synchronous write port, one combinational read port; sync_fifo instantiates it and owns pointers, flags and read register.
- Elaboration check: AF_TH and AE_TH within 0..2**ADD.

## Test plan
- Reset then idle (ADD=3, DATA=8, AF_TH=6, AE_TH=1): empty=1, almost_empty=1, full=0, count=0, rvalid=0.
- Write 0x01..0x08 on 8 consecutive cycles, FWFT=0: almost_full after 6th write, full and count=8 after 8th; 9th write 0xFF sets ovf, count stays 8; then 8 reads return 0x01..0x08 each one cycle after r_en with rvalid=1; empty=1 after last.
- Read while empty: r_en for 1 cycle -> unf=1, rvalid stays 0; clr_err -> unf=0.
- Simultaneous read+write at count=4 for 20 cycles: count stays 4, data order preserved across pointer wrap.
- Full with simultaneous r_en and w_en: read returns oldest word, write rejected, ovf=1, count becomes 7.
- FWFT=1: single write 0xA5 into empty -> rdata=0xA5, rvalid=1 next cycle without r_en; r_en pops, empty=1. Flush at count=5 -> count=0, empty=1, ovf/unf unchanged.
